// File: rtl/steer_en_sm.sv
// Rider-presence and steering-enable controller: qualifies total load and left/right balance.
// Define STEER_FAST_SIM_EN to shorten the balance timer to 2**15 cycles for full-chip simulation.
module steer_en_sm #(
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040,
    parameter int          TMR_BITS     = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] left_ld,
    input  logic [11:0] right_ld,
    output logic        en_steer,
    output logic        rider_off
);

`ifdef STEER_FAST_SIM_EN
    localparam int TW = 15;
`else
    localparam int TW = TMR_BITS;
`endif

    // Terminal count minus one is simply all ones at the chosen timer width.
    localparam logic [TW-1:0] TMR_LAST = '1;
    localparam logic [12:0]   SUM_HI   = 13'(MIN_RIDER_WT) + 13'(WT_HYST);
    localparam logic [12:0]   SUM_LO   = 13'(MIN_RIDER_WT) - 13'(WT_HYST);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_STEER_EN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          en_steer_q, en_steer_d;
    logic          rider_off_q, rider_off_d;

    logic [12:0] sum;
    logic [11:0] diff;
    logic        sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;

    always_comb begin
        sum           = {1'b0, left_ld} + {1'b0, right_ld};
        diff          = (left_ld >= right_ld) ? (left_ld - right_ld) : (right_ld - left_ld);
        sum_gt_min    = sum > SUM_HI;
        sum_lt_min    = sum < SUM_LO;
        diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
        diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));
    end

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (sum_gt_min) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Weight loss outranks imbalance; imbalance restarts the stance timer.
                if (sum_lt_min)                state_d = ST_IDLE;
                else if (diff_gt_1_4)          timer_d = '0;
                else if (timer_q == TMR_LAST)  state_d = ST_STEER_EN;
                else                           timer_d = timer_q + 1'b1;
            end
            ST_STEER_EN: begin
                if (sum_lt_min)         state_d = ST_IDLE;
                else if (diff_gt_15_16) state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
        en_steer_d  = (state_d == ST_STEER_EN);
        rider_off_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            en_steer_q  <= en_steer_d;
            rider_off_q <= rider_off_d;
        end
    end

    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;

endmodule

// File: tb/tb_steer_en_sm.sv
// Directed bench for steer_en_sm with a 1024-cycle balance timer.
module tb_steer_en_sm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] left_ld = '0;
    logic [11:0] right_ld = '0;
    logic        en_steer, rider_off;

    int n_tests = 0;
    int n_fail  = 0;

    steer_en_sm #(.TMR_BITS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .left_ld  (left_ld),
        .right_ld (right_ld),
        .en_steer (en_steer),
        .rider_off(rider_off)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] l;
        logic [11:0] r;
        logic        exp_en;
        logic        exp_off;
        string       name;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input logic [11:0] l, input logic [11:0] r);
        left_ld  = l;
        right_ld = r;
    endtask

    task automatic check(input string name, input logic exp_en, input logic exp_off);
        n_tests++;
        if (en_steer !== exp_en || rider_off !== exp_off) begin
            n_fail++;
            $display("FAIL %s: en_steer=%b rider_off=%b, expected en_steer=%b rider_off=%b",
                     name, en_steer, rider_off, exp_en, exp_off);
        end
    endtask

    // Counts edges until en_steer rises, bounded; compares against the expected count.
    task automatic check_rise(input string name, input int exp_n);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (en_steer !== 1'b1 && n < 2000);
        n_tests++;
        if (n != exp_n) begin
            n_fail++;
            $display("FAIL %s: en_steer rose after %0d cycles, expected %0d", name, n, exp_n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_ld(12'h000, 12'h000);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{12'h000, 12'h000, 1'b0, 1'b1, "idle_zero"};
        vecs[1] = '{12'h100, 12'h100, 1'b0, 1'b1, "idle_band_0x200"};
        vecs[2] = '{12'h120, 12'h120, 1'b0, 1'b1, "idle_edge_0x240"};
        vecs[3] = '{12'h121, 12'h120, 1'b0, 1'b0, "enter_wait_0x241"};
        vecs[4] = '{12'h100, 12'h0E0, 1'b0, 1'b0, "wait_band_0x1e0"};
        vecs[5] = '{12'h0E0, 12'h0E0, 1'b0, 1'b0, "wait_edge_0x1c0"};
        vecs[6] = '{12'h0E0, 12'h0DF, 1'b0, 1'b1, "wait_exit_0x1bf"};
        vecs[7] = '{12'h300, 12'h000, 1'b0, 1'b0, "idle_unbal_enter"};
        vecs[8] = '{12'h000, 12'h000, 1'b0, 1'b1, "wait_exit_zero"};

        // Reset state, held through and after release with no load
        do_reset();
        check("reset_held", 1'b0, 1'b1);
        tick();
        check("reset_release", 1'b0, 1'b1);

        // Single-cycle threshold and hysteresis vectors
        for (int i = 0; i < 9; i++) begin
            set_ld(vecs[i].l, vecs[i].r);
            tick();
            check(vecs[i].name, vecs[i].exp_en, vecs[i].exp_off);
        end

        // Balanced stance: WAIT next edge, en_steer 1024 edges later
        do_reset();
        set_ld(12'h180, 12'h180);
        tick();
        check("wait_entry", 1'b0, 1'b0);
        check_rise("balance_timer", 1024);
        check("steer_on", 1'b1, 0);

        // Imbalance mid-WAIT restarts the timer
        do_reset();
        set_ld(12'h180, 12'h180);
        tick();
        repeat (500) tick();
        check("wait_500", 1'b0, 1'b0);
        set_ld(12'h300, 12'h000);
        tick();
        check("imbalance_stays_wait", 1'b0, 1'b0);
        set_ld(12'h180, 12'h180);
        check_rise("timer_restart", 1024);

        // STEER_EN imbalance tolerance, boundary and exit
        set_ld(12'h280, 12'h080);
        tick();
        check("steer_mild_diff", 1'b1, 1'b0);
        set_ld(12'h2E8, 12'h018);
        tick();
        check("steer_diff_edge_0x2d0", 1'b1, 1'b0);
        set_ld(12'h2F0, 12'h010);
        tick();
        check("steer_diff_exit", 1'b0, 1'b0);
        set_ld(12'h180, 12'h180);
        check_rise("reenter_steer", 1024);

        // Hysteresis in STEER_EN
        set_ld(12'h100, 12'h100);
        tick();
        check("steer_band_0x200", 1'b1, 1'b0);
        set_ld(12'h0D8, 12'h0D8);
        tick();
        check("steer_exit_0x1b0", 1'b0, 1'b1);

        // diff exactly sum/4 does not restart the timer
        do_reset();
        set_ld(12'h1E0, 12'h120);
        tick();
        check("wait_entry_diff_edge", 1'b0, 1'b0);
        check_rise("diff_edge_0xc0", 1024);

        // Reset while steering, then re-entry
        set_ld(12'h180, 12'h180);
        rst = 1'b1;
        tick();
        check("reset_in_steer", 1'b0, 1'b1);
        rst = 1'b0;
        tick();
        check("reenter_wait", 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
